// File: rtl/qclk_strobe_gen_pkg.sv
// Shared definitions for the qclk / command-strobe block: default counter width
// and the arm-state encoding.
package qclk_strobe_gen_pkg;

    localparam int unsigned QCLK_WIDTH_DEFAULT = 32;

    typedef enum logic {
        ARMED = 1'b0,
        FIRED = 1'b1
    } arm_state_e;

endpackage

// File: rtl/qclk_strobe_gen_if.sv
// Bus between ctrl/ALU and the qclk strobe generator: load, clear and strobe
// request inputs plus the registered qclk, strobe and late-flag outputs.
interface qclk_strobe_gen_if
    import qclk_strobe_gen_pkg::*;
#(
    parameter int unsigned QCLK_WIDTH = QCLK_WIDTH_DEFAULT
);

    logic                  qclk_load_en;
    logic [QCLK_WIDTH-1:0] qclk_load_val;
    logic                  qclk_rst;
    logic                  c_strobe_enable;
    logic [QCLK_WIDTH-1:0] cmd_time;
    logic                  instr_ptr_en;
    logic                  late_clr;
    logic [QCLK_WIDTH-1:0] qclk_out;
    logic                  cstrobe_out;
    logic                  late_err;

    modport master (
        output qclk_load_en, qclk_load_val, qclk_rst, c_strobe_enable,
               cmd_time, instr_ptr_en, late_clr,
        input  qclk_out, cstrobe_out, late_err
    );

    modport slave (
        input  qclk_load_en, qclk_load_val, qclk_rst, c_strobe_enable,
               cmd_time, instr_ptr_en, late_clr,
        output qclk_out, cstrobe_out, late_err
    );

endinterface

// File: rtl/qclk_strobe_gen.sv
// Timing clock counter with one-ahead command-time compare, a two-state arm FSM
// that blocks repeat strobes while ctrl stalls, and a sticky late-pulse flag.
module qclk_strobe_gen
    import qclk_strobe_gen_pkg::*;
#(
    parameter int unsigned QCLK_WIDTH = QCLK_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    qclk_strobe_gen_if.slave  bus
);

    logic [QCLK_WIDTH-1:0] qclk_q;
    logic [QCLK_WIDTH-1:0] qclk_d;
    logic [QCLK_WIDTH-1:0] diff_c;
    logic                  cstrobe_q;
    logic                  cstrobe_d;
    logic                  late_q;
    logic                  late_d;
    logic                  en_q;
    logic                  ien_q;
    logic                  first_cycle_c;
    logic                  late_set_c;
    arm_state_e            state_q;
    arm_state_e            state_d;

    // qclk next value: soft clear beats load beats increment
    always_comb begin
        qclk_d = qclk_q + QCLK_WIDTH'(1);
        if (bus.qclk_rst) begin
            qclk_d = '0;
        end else if (bus.qclk_load_en) begin
            qclk_d = bus.qclk_load_val;
        end
    end

    // Arm FSM next state and one-ahead strobe compare
    always_comb begin
        state_d   = state_q;
        cstrobe_d = 1'b0;
        unique case (state_q)
            ARMED: begin
                cstrobe_d = bus.c_strobe_enable && (qclk_d == bus.cmd_time);
                if (cstrobe_q && !bus.instr_ptr_en) begin
                    state_d = FIRED;
                end
            end
            FIRED: begin
                if (bus.instr_ptr_en || !bus.c_strobe_enable) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    // Late check on the first cycle of each PULSE: time now or in the past (half-range)
    always_comb begin
        first_cycle_c = bus.c_strobe_enable && (!en_q || ien_q);
        diff_c        = bus.cmd_time - qclk_q;
        late_set_c    = first_cycle_c && ((diff_c == '0) || diff_c[QCLK_WIDTH-1]);
        late_d        = late_q;
        if (late_set_c) begin
            late_d = 1'b1;
        end else if (bus.late_clr) begin
            late_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            qclk_q    <= '0;
            cstrobe_q <= 1'b0;
            late_q    <= 1'b0;
            en_q      <= 1'b0;
            ien_q     <= 1'b0;
            state_q   <= ARMED;
        end else begin
            qclk_q    <= qclk_d;
            cstrobe_q <= cstrobe_d;
            late_q    <= late_d;
            en_q      <= bus.c_strobe_enable;
            ien_q     <= bus.instr_ptr_en;
            state_q   <= state_d;
        end
    end

    assign bus.qclk_out    = qclk_q;
    assign bus.cstrobe_out = cstrobe_q;
    assign bus.late_err    = late_q;

endmodule

// File: tb/tb_qclk_strobe_gen.sv
// Bench for qclk_strobe_gen: a 32-bit instance driven from a vector table and an
// 8-bit instance driven by hand sequences that exercise qclk wrap-around.
module tb_qclk_strobe_gen;

    typedef struct {
        logic        sel8;
        logic        rst_n;
        logic        load_en;
        logic [31:0] load_val;
        logic        qrst;
        logic        en;
        logic [31:0] cmd;
        logic        ien;
        logic        lclr;
        logic [31:0] eq;
        logic        es;
        logic        el;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        s;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic rst32;
    logic rst8;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sbq[$];
    vec_t tbl[$];

    qclk_strobe_gen_if #(.QCLK_WIDTH(32)) if32 ();
    qclk_strobe_gen_if #(.QCLK_WIDTH(8))  if8 ();

    qclk_strobe_gen #(.QCLK_WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .bus(if32));
    qclk_strobe_gen #(.QCLK_WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .bus(if8));

    always #5 clk = ~clk;

    function automatic vec_t mk(logic s8, logic rn, logic ld, logic [31:0] lv, logic qr,
                                logic en, logic [31:0] cmd, logic ien, logic lc,
                                logic [31:0] eq, logic es, logic el);
        vec_t v;
        v.sel8 = s8; v.rst_n = rn; v.load_en = ld; v.load_val = lv; v.qrst = qr;
        v.en = en; v.cmd = cmd; v.ien = ien; v.lclr = lc;
        v.eq = eq; v.es = es; v.el = el;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic step(input vec_t v, input string name);
        exp_t        e;
        logic [31:0] aq;
        logic        as;
        logic        al;
        @(negedge clk);
        if (v.sel8) begin
            rst8                = v.rst_n;
            if8.qclk_load_en    = v.load_en;
            if8.qclk_load_val   = v.load_val[7:0];
            if8.qclk_rst        = v.qrst;
            if8.c_strobe_enable = v.en;
            if8.cmd_time        = v.cmd[7:0];
            if8.instr_ptr_en    = v.ien;
            if8.late_clr        = v.lclr;
        end else begin
            rst32                = v.rst_n;
            if32.qclk_load_en    = v.load_en;
            if32.qclk_load_val   = v.load_val;
            if32.qclk_rst        = v.qrst;
            if32.c_strobe_enable = v.en;
            if32.cmd_time        = v.cmd;
            if32.instr_ptr_en    = v.ien;
            if32.late_clr        = v.lclr;
        end
        e.q = v.eq; e.s = v.es; e.l = v.el;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e  = sbq.pop_front();
        aq = v.sel8 ? {24'h0, if8.qclk_out} : if32.qclk_out;
        as = v.sel8 ? if8.cstrobe_out : if32.cstrobe_out;
        al = v.sel8 ? if8.late_err : if32.late_err;
        n_vec++;
        if (aq !== e.q || as !== e.s || al !== e.l) begin
            n_miss++;
            $display("FAIL %s: got qclk=%h strobe=%b late=%b, want qclk=%h strobe=%b late=%b",
                     name, aq, as, al, e.q, e.s, e.l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  mq;
        logic [7:0]  nq;
        logic [7:0]  d8;
        logic        late8;
        logic        found;

        rst32 = 1'b0; rst8 = 1'b0;
        if32.qclk_load_en = 1'b0; if32.qclk_load_val = '0; if32.qclk_rst = 1'b0;
        if32.c_strobe_enable = 1'b0; if32.cmd_time = '0; if32.instr_ptr_en = 1'b0;
        if32.late_clr = 1'b0;
        if8.qclk_load_en = 1'b0; if8.qclk_load_val = '0; if8.qclk_rst = 1'b0;
        if8.c_strobe_enable = 1'b0; if8.cmd_time = '0; if8.instr_ptr_en = 1'b0;
        if8.late_clr = 1'b0;

        // 32-bit table: reset, count, clear/load priority, on-time pulse, late pulse,
        // wrap, load landing on cmd_time, reset mid-operation
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0));
        for (int i = 1; i <= 3; i++) tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 32'(i),0,0));
        tbl.push_back(mk(0,1,1,32'h1000,1, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,1,32'h1000,0, 0,0,0,0, 32'h1000,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 32'h1001,0,0));
        tbl.push_back(mk(0,1,1,10,0, 0,0,0,0, 10,0,0));
        for (int i = 11; i <= 19; i++) tbl.push_back(mk(0,1,0,0,0, 1,20,0,0, 32'(i),0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,20,0,0, 20,1,0));
        tbl.push_back(mk(0,1,0,0,0, 1,20,1,0, 21,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 22,0,0));
        tbl.push_back(mk(0,1,1,100,0, 0,0,0,0, 100,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,100,0,0, 101,0,1));
        tbl.push_back(mk(0,1,0,0,0, 1,100,0,0, 102,0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,1, 103,0,0));
        tbl.push_back(mk(0,1,1,32'hFFFF_FFFE,0, 0,0,0,0, 32'hFFFF_FFFE,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0, 32'hFFFF_FFFF,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,0, 1,1,0));
        tbl.push_back(mk(0,1,0,0,0, 1,1,1,0, 2,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 3,0,0));
        tbl.push_back(mk(0,1,1,32'h500,0, 1,32'h500,0,0, 32'h500,1,0));
        tbl.push_back(mk(0,1,0,0,0, 1,32'h500,1,0, 32'h501,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 32'h502,0,0));
        tbl.push_back(mk(0,1,1,32'h600,0, 0,0,0,0, 32'h600,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,32'h602,0,0, 32'h601,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,32'h602,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,2,0,0, 1,0,0));
        tbl.push_back(mk(0,1,0,0,0, 1,2,0,0, 2,1,0));
        tbl.push_back(mk(0,1,0,0,0, 1,2,1,0, 3,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 4,0,0));

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl[%0d]", i));

        // 8-bit: late pulse (cmd 50 at qclk 100), set beats clear, fires after wrap
        step(mk(1,0,0,0,0, 0,0,0,0, 0,0,0), "w8_reset0");
        step(mk(1,0,0,0,0, 0,0,0,0, 0,0,0), "w8_reset1");
        step(mk(1,1,1,100,0, 0,0,0,0, 100,0,0), "w8_load100");
        step(mk(1,1,0,0,0, 1,50,0,1, 101,0,1), "w8_late_set_beats_clr");
        mq = 8'd101;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            nq = mq + 8'd1;
            found = (nq == 8'd50);
            step(mk(1,1,0,0,0, 1,50,0,0, {24'h0, nq},found,1), "w8_late_wait");
            mq = nq;
        end
        if (!found) begin
            n_miss++;
            $display("FAIL w8_late_wait: no strobe slot reached, want qclk=32");
        end
        step(mk(1,1,0,0,0, 1,50,1,0, 51,0,1), "w8_late_ack");
        step(mk(1,1,0,0,0, 0,0,0,1, 52,0,0), "w8_late_clr");

        // 8-bit: ctrl stalls (instr_ptr_en stuck 0), no repeat strobe after wrap
        step(mk(1,1,1,3,0, 0,0,0,0, 3,0,0), "st_load3");
        step(mk(1,1,0,0,0, 1,5,0,0, 4,0,0), "st_pre");
        step(mk(1,1,0,0,0, 1,5,0,0, 5,1,0), "st_strobe");
        mq = 8'd5;
        for (int i = 0; i < 300; i++) begin
            mq = mq + 8'd1;
            step(mk(1,1,0,0,0, 1,5,0,0, {24'h0, mq},0,0), "st_fired_hold");
        end
        mq = mq + 8'd1;
        step(mk(1,1,0,0,0, 0,0,0,0, {24'h0, mq},0,0), "st_drop_en");
        d8 = 8'd5 - mq;
        late8 = (d8 == 8'd0) || d8[7];
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            nq = mq + 8'd1;
            found = (nq == 8'd5);
            step(mk(1,1,0,0,0, 1,5,0,0, {24'h0, nq},found,late8), "st_rearmed");
            mq = nq;
        end
        if (!found) begin
            n_miss++;
            $display("FAIL st_rearmed: no strobe slot reached, want qclk=05");
        end
        step(mk(1,1,0,0,0, 1,5,1,0, 6,0,late8), "st_ack");
        step(mk(1,1,0,0,0, 0,0,0,1, 7,0,0), "st_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
